// File: rtl/reg_file_mov.sv
`default_nettype none
//============================================================================
// Module   : reg_file_mov
// Purpose  : Parametrised move-style register bank. Each accepted operation
//            performs one register-to-register move or immediate load.
//            Two addresses are handshaked endpoints: IN (valid/ready input
//            peripheral) and ALU_ANS (result captured on alu_done). Writing
//            ALU_Y launches the ALU with a one-cycle alu_go pulse.
// Ports    : clk, rst          - clock, async active-high reset
//            op_valid/op_ready - operation handshake from the decoder
//            op_imm, from_addr, to_addr, imm_data - operation fields
//            in_data/in_valid/in_ready - input peripheral handshake
//            alu_x, alu_y, alu_go, alu_ans, alu_done - ALU interface
//            err               - one-cycle pulse after a write to IN/ANS
//            dbg_addr/dbg_data - combinational debug read port
// Revision : 1.0 - initial release
//============================================================================
module reg_file_mov #(
    parameter int                  WORD_LEN     = 16,
    parameter int                  ADDR_LEN     = 4,
    parameter logic [ADDR_LEN-1:0] IN_ADDR      = 4'ha,
    parameter logic [ADDR_LEN-1:0] ALU_X_ADDR   = 4'hb,
    parameter logic [ADDR_LEN-1:0] ALU_Y_ADDR   = 4'hc,
    parameter logic [ADDR_LEN-1:0] ALU_ANS_ADDR = 4'hd
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_imm,
    input  logic [ADDR_LEN-1:0] from_addr,
    input  logic [ADDR_LEN-1:0] to_addr,
    input  logic [WORD_LEN-1:0] imm_data,
    input  logic [WORD_LEN-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WORD_LEN-1:0] alu_x,
    output logic [WORD_LEN-1:0] alu_y,
    output logic                alu_go,
    input  logic [WORD_LEN-1:0] alu_ans,
    input  logic                alu_done,
    output logic                err,
    input  logic [ADDR_LEN-1:0] dbg_addr,
    output logic [WORD_LEN-1:0] dbg_data
);

    localparam int DEPTH = 2**ADDR_LEN;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_IN  = 2'd1,
        S_WAIT_ALU = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_LEN-1:0] r_dest;
    logic [ADDR_LEN-1:0] w_dest_next;
    logic                r_ans_valid;
    logic                r_go;
    logic                r_err;

    // The IN and ANS slots of the array hold the last consumed input word
    // and the last captured ALU result; normal writes never land there.
    logic [WORD_LEN-1:0] r_regs [DEPTH];

    logic                w_wr;
    logic [ADDR_LEN-1:0] w_wa;
    logic [WORD_LEN-1:0] w_wd;
    logic                w_in_ready;
    logic                w_bad;
    logic                w_store;
    logic                w_y_write;

    // Next-state and single write-port selection
    always_comb begin
        w_state_next = r_state;
        w_dest_next  = r_dest;
        w_wr         = 1'b0;
        w_wa         = to_addr;
        w_wd         = imm_data;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_imm) begin
                        w_wr = 1'b1;
                    end else if (from_addr == IN_ADDR) begin
                        w_wd = in_data;
                        if (in_valid) begin
                            w_in_ready = 1'b1;
                            w_wr       = 1'b1;
                        end else begin
                            w_state_next = S_WAIT_IN;
                            w_dest_next  = to_addr;
                        end
                    end else if (from_addr == ALU_ANS_ADDR) begin
                        w_wd = r_regs[ALU_ANS_ADDR];
                        if (r_ans_valid) begin
                            w_wr = 1'b1;
                        end else begin
                            w_state_next = S_WAIT_ALU;
                            w_dest_next  = to_addr;
                        end
                    end else begin
                        w_wr = 1'b1;
                        w_wd = r_regs[from_addr];
                    end
                end
            end
            S_WAIT_IN: begin
                w_wa = r_dest;
                w_wd = in_data;
                if (in_valid) begin
                    w_in_ready   = 1'b1;
                    w_wr         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_ALU: begin
                w_wa = r_dest;
                w_wd = r_regs[ALU_ANS_ADDR];
                if (r_ans_valid) begin
                    w_wr         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // IN and ANS are read-only: such writes are dropped and flagged
    assign w_bad     = w_wr && ((w_wa == IN_ADDR) || (w_wa == ALU_ANS_ADDR));
    assign w_store   = w_wr && !w_bad;
    assign w_y_write = w_store && (w_wa == ALU_Y_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_regs[w_wa] <= w_wd;
            end
            if (w_in_ready) begin
                r_regs[IN_ADDR] <= in_data;
            end
            if (alu_done) begin
                r_regs[ALU_ANS_ADDR] <= alu_ans;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dest      <= '0;
            r_ans_valid <= 1'b0;
            r_go        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_dest  <= w_dest_next;
            r_go    <= w_y_write;
            r_err   <= w_bad;
            // A Y write starts a new computation, so it overrides a
            // coincident done from the previous one.
            if (w_y_write) begin
                r_ans_valid <= 1'b0;
            end else if (alu_done) begin
                r_ans_valid <= 1'b1;
            end
        end
    end

    assign op_ready = (r_state == S_IDLE);
    assign in_ready = w_in_ready;
    assign alu_x    = r_regs[ALU_X_ADDR];
    assign alu_y    = r_regs[ALU_Y_ADDR];
    assign alu_go   = r_go;
    assign err      = r_err;
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mov.sv
`default_nettype none
//============================================================================
// Module   : tb_reg_file_mov
// Purpose  : Self-checking bench for reg_file_mov. A behavioural model of the
//            register bank (array + pending-operation record) predicts every
//            output each cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
//============================================================================
module tb_reg_file_mov;

    localparam int         W   = 16;
    localparam int         A   = 4;
    localparam logic [3:0] IN  = 4'ha;
    localparam logic [3:0] X   = 4'hb;
    localparam logic [3:0] Y   = 4'hc;
    localparam logic [3:0] ANS = 4'hd;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic         op_imm = 1'b0;
    logic [A-1:0] from_addr = '0;
    logic [A-1:0] to_addr = '0;
    logic [W-1:0] imm_data = '0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic         alu_go;
    logic [W-1:0] alu_ans = '0;
    logic         alu_done = 1'b0;
    logic         err;
    logic [A-1:0] dbg_addr = '0;
    logic [W-1:0] dbg_data;

    reg_file_mov dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_imm    (op_imm),
        .from_addr (from_addr),
        .to_addr   (to_addr),
        .imm_data  (imm_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_go    (alu_go),
        .alu_ans   (alu_ans),
        .alu_done  (alu_done),
        .err       (err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: register contents, result-valid flag, and the
    // operation waiting on a source (0 none, 1 input port, 2 ALU result).
    logic [W-1:0] m_reg [16];
    bit           m_av;
    int           m_pend;
    logic [3:0]   m_dest;
    bit           m_go;
    bit           m_err;

    int checks   = 0;
    int failures = 0;
    int cnt_go, cnt_err, cnt_irdy, cnt_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_av   = 0;
        m_pend = 0;
        m_dest = '0;
        m_go   = 0;
        m_err  = 0;
    endtask

    task automatic clear_counts();
        cnt_go = 0; cnt_err = 0; cnt_irdy = 0; cnt_busy = 0;
    endtask

    // Called at a falling edge with inputs already driven; checks the cycle
    // against the model, advances the model across the rising edge and
    // returns at the next falling edge.
    task automatic step();
        bit         irdy, wr, bad;
        logic [3:0] wa;
        logic [W-1:0] wd;
        int         pend_n;
        logic [3:0] dest_n;
        #1;
        if (rst) model_reset();
        irdy = 0; wr = 0; wa = '0; wd = '0;
        pend_n = m_pend; dest_n = m_dest;
        if (!rst) begin
            if (m_pend == 0 && op_valid) begin
                if (op_imm) begin
                    wr = 1; wa = to_addr; wd = imm_data;
                end else if (from_addr == IN) begin
                    if (in_valid) begin irdy = 1; wr = 1; wa = to_addr; wd = in_data; end
                    else begin pend_n = 1; dest_n = to_addr; end
                end else if (from_addr == ANS) begin
                    if (m_av) begin wr = 1; wa = to_addr; wd = m_reg[ANS]; end
                    else begin pend_n = 2; dest_n = to_addr; end
                end else begin
                    wr = 1; wa = to_addr; wd = m_reg[from_addr];
                end
            end else if (m_pend == 1 && in_valid) begin
                irdy = 1; wr = 1; wa = m_dest; wd = in_data; pend_n = 0;
            end else if (m_pend == 2 && m_av) begin
                wr = 1; wa = m_dest; wd = m_reg[ANS]; pend_n = 0;
            end
        end
        chk("op_ready", op_ready, (m_pend == 0));
        chk("in_ready", in_ready, irdy);
        chk("alu_x", alu_x, m_reg[X]);
        chk("alu_y", alu_y, m_reg[Y]);
        chk("alu_go", alu_go, m_go);
        chk("err", err, m_err);
        chk("dbg_data", dbg_data, m_reg[dbg_addr]);
        if (alu_go)    cnt_go++;
        if (err)       cnt_err++;
        if (in_ready)  cnt_irdy++;
        if (!op_ready) cnt_busy++;
        if (rst) begin
            @(negedge clk);
            return;
        end
        @(posedge clk);
        bad   = wr && (wa == IN || wa == ANS);
        m_err = bad;
        m_go  = wr && !bad && (wa == Y);
        if (wr && !bad) m_reg[wa] = wd;
        if (irdy)       m_reg[IN] = in_data;
        if (alu_done)   m_reg[ANS] = alu_ans;
        if (m_go)          m_av = 0;
        else if (alu_done) m_av = 1;
        m_pend = pend_n;
        m_dest = dest_n;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        op_valid = 0;
        repeat (n) step();
    endtask

    task automatic do_op(input bit imm, input logic [3:0] f, input logic [3:0] t,
                         input logic [W-1:0] d);
        op_valid = 1; op_imm = imm; from_addr = f; to_addr = t; imm_data = d;
        step();
        op_valid = 0;
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [W-1:0] exp);
        dbg_addr = a;
        #1 chk(name, dbg_data, exp);
        step();
    endtask

    initial begin
        model_reset();
        clear_counts();
        @(negedge clk);
        rst = 1;
        step();
        step();
        rst = 0;

        // Immediate load then register move
        clear_counts();
        do_op(1, 4'h0, 4'h1, 16'h1234);
        do_op(0, 4'h1, 4'h2, 16'h0);
        peek("lit_r2", 4'h2, 16'h1234);
        chk("lit_busy0", cnt_busy, 0);
        chk("lit_err0", cnt_err, 0);

        // Input move with stall
        clear_counts();
        in_valid = 0;
        do_op(0, IN, 4'h3, 16'h0);
        idle(2);
        in_valid = 1; in_data = 16'hBEEF;
        step();
        in_valid = 0; in_data = 16'h0;
        peek("lit_r3", 4'h3, 16'hBEEF);
        chk("lit_in_busy", cnt_busy, 3);
        chk("lit_in_ready_pulses", cnt_irdy, 1);

        // ALU launch, stall on result, repeated result read
        clear_counts();
        do_op(1, 4'h0, X, 16'd5);
        do_op(1, 4'h0, Y, 16'd7);
        #1 chk("lit_go_after_y", alu_go, 1);
        chk("lit_alu_x", alu_x, 16'd5);
        chk("lit_alu_y", alu_y, 16'd7);
        do_op(0, ANS, 4'h4, 16'h0);
        idle(2);
        alu_done = 1; alu_ans = 16'h000C;
        step();
        alu_done = 0; alu_ans = 16'h0;
        idle(2);
        clear_counts();
        do_op(0, ANS, 4'h5, 16'h0);
        chk("lit_ans_nostall", cnt_busy, 0);
        peek("lit_r4", 4'h4, 16'h000C);
        peek("lit_r5", 4'h5, 16'h000C);

        // Write to read-only result address
        clear_counts();
        do_op(1, 4'h0, ANS, 16'h0055);
        #1 chk("lit_err_pulse", err, 1);
        chk("lit_op_ready_err", op_ready, 1);
        peek("lit_ans_kept", ANS, 16'h000C);
        chk("lit_err_once", cnt_err, 1);

        // Done coinciding with a Y write: result captured but not valid
        alu_done = 1; alu_ans = 16'h0099;
        do_op(1, 4'h0, Y, 16'h0003);
        alu_done = 0; alu_ans = 16'h0;
        peek("lit_ans_captured", ANS, 16'h0099);
        clear_counts();
        do_op(0, ANS, 4'h6, 16'h0);
        idle(2);
        chk("lit_ans_stall", cnt_busy, 2);
        alu_done = 1; alu_ans = 16'h0077;
        step();
        alu_done = 0; alu_ans = 16'h0;
        idle(1);
        peek("lit_r6", 4'h6, 16'h0077);

        // Reset while waiting on input
        do_op(0, IN, 4'h7, 16'h0);
        idle(1);
        rst = 1;
        #1 chk("lit_rst_ready", op_ready, 1);
        chk("lit_rst_in_ready", in_ready, 0);
        step();
        rst = 0;
        clear_counts();
        in_valid = 1; in_data = 16'hDEAD;
        idle(2);
        chk("lit_late_in_ignored", cnt_irdy, 0);
        in_valid = 0; in_data = 16'h0;
        peek("lit_r7_zero", 4'h7, 16'h0);
        peek("lit_r1_zero", 4'h1, 16'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] f;
            op_valid  = ($urandom_range(0, 1) == 1);
            op_imm    = ($urandom_range(0, 3) == 0);
            f         = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       from_addr = IN;
                1:       from_addr = ANS;
                default: from_addr = f;
            endcase
            to_addr   = ($urandom_range(0, 3) == 0) ? Y : 4'($urandom_range(0, 15));
            imm_data  = 16'($urandom);
            in_valid  = ($urandom_range(0, 9) < 3);
            in_data   = 16'($urandom);
            alu_done  = ($urandom_range(0, 9) == 0);
            alu_ans   = 16'($urandom);
            dbg_addr  = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; op_valid = 0; in_valid = 0; alu_done = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
